// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte-wide 8N1 UART transmitter fed by a store FIFO. Single-cycle
//            CPU stores are queued and sent back-to-back on the serial line
//            at a fixed clock-per-bit ratio.
// Ports    : clk        - system clock, rising edge
//            rstn       - asynchronous active-low reset (sync release upstream)
//            wr_en      - push wr_data this cycle
//            wr_data    - byte to transmit
//            full       - FIFO holds FIFO_DEPTH entries
//            fifo_count - queued entries (excludes the byte on the wire)
//            tx_busy    - a frame is in progress
//            overflow   - sticky, a write arrived while full
//            uart_tx    - serial line, idle high, driven from a flop
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             wr_en,
  input  logic [7:0]                       wr_data,
  output logic                             full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             tx_busy,
  output logic                             overflow,
  output logic                             uart_tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  state_t            state;
  state_t            state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_nxt;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_nxt;
  logic [7:0]        shift;
  logic [7:0]        shift_nxt;
  logic              tx_nxt;
  logic              pop;
  logic              push;
  logic              baud_end;
  logic [CNT_W-1:0]  count_nxt;

  // full is the registered pre-edge state, so a same-edge pop cannot
  // make room for a write.
  assign push     = wr_en && !full;
  assign baud_end = (baud_cnt == BAUD_LAST);

  // Next-state / datapath logic for the serialiser.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = uart_tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        baud_nxt = '0;
        if (fifo_count != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
          tx_nxt    = shift[0];
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt   = bit_idx + 3'd1;
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          // Chain straight into the next start bit when data is waiting.
          if (fifo_count != '0) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CNT_W'(1);
      2'b01:   count_nxt = fifo_count - CNT_W'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      uart_tx    <= 1'b1;
      tx_busy    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_idx    <= bit_nxt;
      shift      <= shift_nxt;
      uart_tx    <= tx_nxt;
      tx_busy    <= (state_nxt != IDLE);
      fifo_count <= count_nxt;
      full       <= (count_nxt == CNT_FULL);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo. Instance a runs at 4 clocks
//            per bit with a 16-deep FIFO and is compared every cycle against a
//            frame-level queue model; instance b runs at 1 clock per bit and is
//            checked against a vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int CPB     = 4;
  localparam int DEPTH   = 16;
  localparam int CPB_B   = 1;
  localparam int DEPTH_B = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       a_we;
  logic [7:0] a_wd;
  logic       a_full;
  logic [4:0] a_cnt;
  logic       a_busy;
  logic       a_ovf;
  logic       a_tx;
  logic       b_we;
  logic [7:0] b_wd;
  logic       b_full;
  logic [2:0] b_cnt;
  logic       b_busy;
  logic       b_ovf;
  logic       b_tx;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_a (
    .clk(clk), .rstn(rstn), .wr_en(a_we), .wr_data(a_wd), .full(a_full),
    .fifo_count(a_cnt), .tx_busy(a_busy), .overflow(a_ovf), .uart_tx(a_tx)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH_B)) u_b (
    .clk(clk), .rstn(rstn), .wr_en(b_we), .wr_data(b_wd), .full(b_full),
    .fifo_count(b_cnt), .tx_busy(b_busy), .overflow(b_ovf), .uart_tx(b_tx)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Frame-level model: a byte queue plus the frame currently on the wire,
  // tracked as a cycle offset into a 10-bit {stop, data, start} vector.
  byte unsigned mq[$];
  logic [9:0]   mframe;
  int           mpos;
  bit           mact;
  bit           movf;

  function automatic void model_reset();
    mq.delete();
    mframe = '1;
    mpos   = 0;
    mact   = 1'b0;
    movf   = 1'b0;
  endfunction

  function automatic void model_edge(input bit we, input logic [7:0] wd);
    int pre;
    bit take;
    pre  = mq.size();
    take = 1'b0;
    if (!mact) take = (pre > 0);
    else if (mpos == 10*CPB - 1) begin
      if (pre > 0) take = 1'b1;
      else mact = 1'b0;
    end else mpos++;
    if (take) begin
      mframe = {1'b1, mq.pop_front(), 1'b0};
      mpos   = 0;
      mact   = 1'b1;
    end
    if (we) begin
      if (pre == DEPTH) movf = 1'b1;
      else mq.push_back(wd);
    end
  endfunction

  function automatic logic model_tx();
    return mact ? mframe[mpos / CPB] : 1'b1;
  endfunction

  task automatic compare_a();
    check("uart_tx",    a_tx,   model_tx());
    check("tx_busy",    a_busy, mact);
    check("fifo_count", a_cnt,  mq.size());
    check("full",       a_full, (mq.size() == DEPTH));
    check("overflow",   a_ovf,  movf);
  endtask

  // One clock: advance the model with the inputs about to be sampled,
  // then compare just after the edge.
  task automatic step();
    model_edge(a_we, a_wd);
    @(posedge clk);
    #1;
    compare_a();
  endtask

  task automatic write_a(input logic [7:0] d);
    a_we = 1'b1;
    a_wd = d;
    step();
    a_we = 1'b0;
  endtask

  // Reset asserted between edges; uart_tx must rise without a clock.
  task automatic do_reset(input string tag);
    a_we = 1'b0;
    b_we = 1'b0;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check({tag, "_tx_async"},   a_tx,   1);
    check({tag, "_busy_async"}, a_busy, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    compare_a();
  endtask

  typedef struct packed {
    logic       we;
    logic [7:0] d;
    logic       tx;
    logic       busy;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         busy_cycles;
    logic [7:0] pat;
    int         k;

    rstn = 1'b0;
    a_we = 1'b0;
    a_wd = '0;
    b_we = 1'b0;
    b_wd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    compare_a();
    check("b_reset_tx",   b_tx,   1);
    check("b_reset_busy", b_busy, 0);
    check("b_reset_cnt",  b_cnt,  0);
    check("b_reset_ovf",  b_ovf,  0);

    // ---- single 0x55 frame ----
    write_a(8'h55);
    check("t1_tx_high_at_write", a_tx, 1);
    step();
    check("t1_start_low", a_tx, 0);
    busy_cycles = int'(a_busy);
    repeat (50) begin
      step();
      busy_cycles += int'(a_busy);
    end
    check("t1_busy_cycles", busy_cycles, 40);

    // ---- three consecutive writes: pop at the second edge keeps count at 1 ----
    busy_cycles = 0;
    a_we = 1'b1;
    a_wd = 8'h01; step(); check("t2_cnt_e1", a_cnt, 1); busy_cycles += int'(a_busy);
    a_wd = 8'h80; step(); check("t2_cnt_e2", a_cnt, 1); busy_cycles += int'(a_busy);
    a_wd = 8'hFF; step(); check("t2_cnt_e3", a_cnt, 2); busy_cycles += int'(a_busy);
    a_we = 1'b0;
    step(); check("t2_cnt_e4", a_cnt, 2); busy_cycles += int'(a_busy);
    for (k = 0; k < 200 && (mact || mq.size() != 0); k++) begin
      step();
      busy_cycles += int'(a_busy);
    end
    check("t2_drained", int'(mact || mq.size() != 0), 0);
    check("t2_busy_cycles", busy_cycles, 120);

    // ---- fill: 17 accepted, 18th dropped, overflow sticky ----
    for (int i = 0; i < 17; i++) write_a(8'h10 + 8'(i));
    check("t3_full", a_full, 1);
    check("t3_cnt_full", a_cnt, DEPTH);
    check("t3_ovf_before", a_ovf, 0);
    write_a(8'hEE);
    check("t3_ovf_set", a_ovf, 1);
    check("t3_cnt_after_drop", a_cnt, DEPTH);
    repeat (60) step();
    check("t3_ovf_sticky", a_ovf, 1);

    // ---- write while full at the stop-end pop edge ----
    do_reset("t4");
    for (int i = 0; i < 17; i++) write_a(8'h30 + 8'(i));
    check("t4_full", a_full, 1);
    for (k = 0; k < 100 && !(mact && mpos == 10*CPB - 1); k++) step();
    check("t4_reached_stop_end", int'(mact && mpos == 10*CPB - 1), 1);
    a_we = 1'b1;
    a_wd = 8'hC3;
    step();
    a_we = 1'b0;
    check("t4_ovf", a_ovf, 1);
    check("t4_cnt", a_cnt, DEPTH - 1);
    check("t4_not_full", a_full, 0);

    // ---- reset in the middle of a data bit ----
    for (k = 0; k < 100 && !(mact && mpos == 3*CPB + 1); k++) step();
    check("t5_reached_data", int'(mact && mpos == 3*CPB + 1), 1);
    do_reset("t5");
    check("t5_cnt", a_cnt, 0);
    check("t5_busy", a_busy, 0);
    busy_cycles = 0;
    repeat (60) begin
      step();
      busy_cycles += int'(a_busy);
    end
    check("t5_no_frame", busy_cycles, 0);

    // ---- one clock per bit, 0xA5: 0,1,0,1,0,0,1,0,1,1 ----
    pat = 8'hA5;
    tbl[0] = '{we: 1'b1, d: 8'hA5, tx: 1'b1, busy: 1'b0, cnt: 3'd1};
    tbl[1] = '{we: 1'b0, d: 8'h00, tx: 1'b0, busy: 1'b1, cnt: 3'd0};
    for (int i = 0; i < 8; i++)
      tbl[2+i] = '{we: 1'b0, d: 8'h00, tx: pat[i], busy: 1'b1, cnt: 3'd0};
    tbl[10] = '{we: 1'b0, d: 8'h00, tx: 1'b1, busy: 1'b1, cnt: 3'd0};
    tbl[11] = '{we: 1'b0, d: 8'h00, tx: 1'b1, busy: 1'b0, cnt: 3'd0};
    for (int i = 0; i < 12; i++) begin
      b_we = tbl[i].we;
      b_wd = tbl[i].d;
      step();
      b_we = 1'b0;
      check($sformatf("t6_tx[%0d]", i),   b_tx,   tbl[i].tx);
      check($sformatf("t6_busy[%0d]", i), b_busy, tbl[i].busy);
      check($sformatf("t6_cnt[%0d]", i),  b_cnt,  tbl[i].cnt);
    end

    // ---- random traffic: sparse writes with periodic bursts ----
    do_reset("rnd");
    for (int c = 0; c < 4000; c++) begin
      a_we = ($urandom_range(0, 99) < (((c % 800) < 40) ? 90 : 3));
      a_wd = 8'($urandom);
      step();
    end
    a_we = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
